// File: rtl/pc_seq_pkg.sv
// Shared op encodings, condition-select constants and condition helper for pc_sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'd0,
        OP_BRA   = 3'd1,
        OP_BCOND = 3'd2,
        OP_JMP   = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5
    } op_e;

    localparam logic CSEL_CARRY = 1'b0;
    localparam logic CSEL_ZERO  = 1'b1;

    // Picks the flag named by csel; the caller applies inversion.
    function automatic logic sel_cond(input logic csel, input logic carry, input logic zero);
        logic r;
        r = carry;
        case (csel)
            CSEL_CARRY: r = carry;
            CSEL_ZERO:  r = zero;
            default:    r = carry;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_sequencer; push/pop are ignored when full/empty.
module pc_ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    top_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Index wraps when empty; data is then don't-care since pop is blocked.
    assign top_idx = IW'(count - CW'(1));
    assign data    = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[IW'(count)] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with relative/absolute branches and optional return
// stack (enabled by defining PC_SEQUENCER_RETSTACK_EN).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned OFFSET_WIDTH = 8,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned RESET_ADDR   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    advance,
    input  logic [2:0]              op,
    input  logic                    csel,
    input  logic                    cinv,
    input  logic                    carry,
    input  logic                    zero,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [ADDR_WIDTH-1:0]   target,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    taken,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned XW = ADDR_WIDTH - OFFSET_WIDTH;

    if (ADDR_WIDTH < OFFSET_WIDTH + 1 || STACK_DEPTH < 2 ||
        (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_param_check
        $error("pc_sequencer: illegal ADDR_WIDTH/OFFSET_WIDTH/STACK_DEPTH");
    end

    logic [AW-1:0] seq_c;
    logic [AW-1:0] rel_c;
    logic [AW-1:0] pc_d;
    logic          taken_d;
    logic          cond_c;

    assign seq_c  = pc + AW'(1);
    assign rel_c  = pc + {{XW{offset[OFFSET_WIDTH-1]}}, offset};
    assign cond_c = sel_cond(csel, carry, zero) ^ cinv;

`ifdef PC_SEQUENCER_RETSTACK_EN
    logic          push_c;
    logic          pop_c;
    logic          ovf_set_c;
    logic          unf_set_c;
    logic [AW-1:0] top_c;
`endif

    // Next-pc selection; NEXT and the unused encodings fall through to seq.
    always_comb begin
        pc_d    = seq_c;
        taken_d = 1'b0;
`ifdef PC_SEQUENCER_RETSTACK_EN
        push_c    = 1'b0;
        pop_c     = 1'b0;
        ovf_set_c = 1'b0;
        unf_set_c = 1'b0;
`endif
        case (op)
            OP_BRA: begin
                pc_d    = rel_c;
                taken_d = 1'b1;
            end
            OP_BCOND: begin
                if (cond_c) begin
                    pc_d    = rel_c;
                    taken_d = 1'b1;
                end
            end
            OP_JMP: begin
                pc_d    = target;
                taken_d = 1'b1;
            end
            OP_CALL: begin
                pc_d    = rel_c;
                taken_d = 1'b1;
`ifdef PC_SEQUENCER_RETSTACK_EN
                if (stack_full) ovf_set_c = 1'b1;
                else            push_c    = 1'b1;
`endif
            end
`ifdef PC_SEQUENCER_RETSTACK_EN
            OP_RET: begin
                if (stack_empty) begin
                    unf_set_c = 1'b1;
                end else begin
                    pc_d    = top_c;
                    taken_d = 1'b1;
                    pop_c   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= AW'(RESET_ADDR);
            taken <= 1'b0;
        end else if (advance) begin
            pc    <= pc_d;
            taken <= taken_d;
        end
    end

`ifdef PC_SEQUENCER_RETSTACK_EN
    pc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (AW)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (advance && push_c),
        .pop   (advance && pop_c),
        .wdata (seq_c),
        .data  (top_c),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (advance) begin
            if (ovf_set_c) overflow  <= 1'b1;
            if (unf_set_c) underflow <= 1'b1;
        end
    end
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign overflow    = 1'b0;
    assign underflow   = 1'b0;
`endif

endmodule
